// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory handshake plus the held-instruction
// interface to decode and the next-PC controls coming back from it.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_encoding;
  logic [31:0] inst_pc;
  logic [1:0]  next_pc_sel;
  logic [31:0] pc_imm;
  logic [31:0] jalr_target;
  logic        misaligned;
  logic        fetch_timeout;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_encoding, inst_pc,
           misaligned, fetch_timeout,
    input  imem_ack, imem_rdata, inst_ready, next_pc_sel, pc_imm, jalr_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_encoding, inst_pc,
           misaligned, fetch_timeout,
    output imem_ack, imem_rdata, inst_ready, next_pc_sel, pc_imm, jalr_target
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, reads one instruction at a time
// over req/ack and holds it for decode until it is retired.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          STALL_LIMIT = 16
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);

  localparam int              CW        = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0]   STALL_MAX = CW'(STALL_LIMIT);
  localparam logic [CW-1:0]   STALL_HIT = CW'(STALL_LIMIT - 1);
  localparam logic [31:0]     NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic          r_suppress;
  logic [CW-1:0] r_stall_cnt;
  logic          r_inst_valid;
  logic [31:0]   r_inst_encoding;
  logic [31:0]   r_inst_pc;
  logic          r_misaligned;
  logic          r_fetch_timeout;

  logic          w_req;
  logic [31:0]   w_next_pc;
  logic          w_target_bad;

  // Request is withheld for one cycle after reset so a stale ack cannot land.
  assign w_req = (r_state == ST_FETCH) && !r_suppress;

  // JALR clears bit 0 before the alignment check, so only bit 1 can fault there.
  always_comb begin
    w_next_pc = r_inst_pc + 32'd4;
    case (bus.next_pc_sel)
      2'b00:   w_next_pc = r_inst_pc + 32'd4;
      2'b01:   w_next_pc = r_inst_pc + bus.pc_imm;
      2'b10:   w_next_pc = {bus.jalr_target[31:1], 1'b0};
      2'b11:   w_next_pc = r_inst_pc + 32'd4;
      default: w_next_pc = r_inst_pc + 32'd4;
    endcase
  end

  assign w_target_bad = (w_next_pc[1:0] != 2'b00);

  // Fetch FSM with the held instruction, PC and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_FETCH;
      r_pc            <= RESET_PC;
      r_suppress      <= 1'b1;
      r_stall_cnt     <= '0;
      r_inst_valid    <= 1'b0;
      r_inst_encoding <= NOP;
      r_inst_pc       <= RESET_PC;
      r_misaligned    <= 1'b0;
      r_fetch_timeout <= 1'b0;
    end else begin
      r_suppress <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (w_req && bus.imem_ack) begin
            r_inst_encoding <= bus.imem_rdata;
            r_inst_pc       <= r_pc;
            r_inst_valid    <= 1'b1;
            r_stall_cnt     <= '0;
            r_state         <= ST_HOLD;
          end else if (w_req) begin
            if (r_stall_cnt != STALL_MAX) begin
              r_stall_cnt <= r_stall_cnt + CW'(1);
            end else begin
              r_stall_cnt <= r_stall_cnt;
            end
            if (r_stall_cnt == STALL_HIT) begin
              r_fetch_timeout <= 1'b1;
            end else begin
              r_fetch_timeout <= r_fetch_timeout;
            end
          end else begin
            r_stall_cnt <= r_stall_cnt;
          end
        end
        ST_HOLD: begin
          if (bus.inst_ready) begin
            r_inst_valid <= 1'b0;
            r_pc         <= w_next_pc;
            if (w_target_bad) begin
              r_misaligned <= 1'b1;
              r_state      <= ST_HALT;
            end else begin
              r_state      <= ST_FETCH;
            end
          end else begin
            r_state <= ST_HOLD;
          end
        end
        ST_HALT: begin
          r_state      <= ST_HALT;
          r_inst_valid <= 1'b0;
        end
        default: begin
          r_state      <= ST_HALT;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req      = w_req;
  assign bus.imem_addr     = r_pc;
  assign bus.inst_valid    = r_inst_valid;
  assign bus.inst_encoding = r_inst_encoding;
  assign bus.inst_pc       = r_inst_pc;
  assign bus.misaligned    = r_misaligned;
  assign bus.fetch_timeout = r_fetch_timeout;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each acked fetch pushes the expected
// instruction/PC pair, popped when decode sees inst_valid.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] enc;
  } fetch_exp_t;

  logic clk;
  logic rst;
  fetch_if bus ();

  int n_tests = 0;
  int n_fails = 0;
  fetch_exp_t sb[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .STALL_LIMIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req",     {31'd0, bus.imem_req},      32'd0);
    chk("rst_addr",    bus.imem_addr,              32'h0000_0000);
    chk("rst_valid",   {31'd0, bus.inst_valid},    32'd0);
    chk("rst_enc",     bus.inst_encoding,          32'h0000_0013);
    chk("rst_pc",      bus.inst_pc,                32'h0000_0000);
    chk("rst_misal",   {31'd0, bus.misaligned},    32'd0);
    chk("rst_timeout", {31'd0, bus.fetch_timeout}, 32'd0);
  endtask

  task automatic check_out();
    fetch_exp_t e;
    chk("inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("sb_depth", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("inst_enc", bus.inst_encoding, e.enc);
      chk("inst_pc",  bus.inst_pc,       e.pc);
    end
  endtask

  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] rdata, input int waits);
    int n = 0;
    @(negedge clk);
    while (!bus.imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, bus.imem_req}, 32'd1);
    chk("fetch_addr", bus.imem_addr, exp_addr);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      chk("wait_valid", {31'd0, bus.inst_valid}, 32'd0);
      chk("wait_req",   {31'd0, bus.imem_req},   32'd1);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    sb.push_back('{pc: exp_addr, enc: rdata});
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    check_out();
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
  endtask

  task automatic retire(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] jt);
    bus.next_pc_sel = sel;
    bus.pc_imm      = imm;
    bus.jalr_target = jt;
    bus.inst_ready  = 1'b1;
    @(negedge clk);
    bus.inst_ready  = 1'b0;
    bus.next_pc_sel = 2'b00;
    bus.pc_imm      = 32'h0000_0000;
    bus.jalr_target = 32'h0000_0000;
    chk("valid_cleared", {31'd0, bus.inst_valid}, 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0000_0000;
    bus.inst_ready  = 1'b0;
    bus.next_pc_sel = 2'b00;
    bus.pc_imm      = 32'h0000_0000;
    bus.jalr_target = 32'h0000_0000;
    repeat (3) @(negedge clk);
    chk_reset_vals();

    // Release reset with ack already high: ignored during the suppress cycle.
    rst            = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    #1;
    chk("first_cycle_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    chk("second_cycle_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("second_cycle_addr", bus.imem_addr, 32'h0000_0000);
    sb.push_back('{pc: 32'h0000_0000, enc: 32'h0050_0093});
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check_out();

    // Sequential fetch with wait states.
    retire(2'b00, 32'h0, 32'h0);
    do_fetch(32'h0000_0004, 32'h0010_0113, 3);
    retire(2'b00, 32'h0, 32'h0);
    do_fetch(32'h0000_0008, 32'h0020_0193, 3);
    chk("no_timeout", {31'd0, bus.fetch_timeout}, 32'd0);
    retire(2'b00, 32'h0, 32'h0);
    do_fetch(32'h0000_000C, 32'h0030_0213, 1);
    retire(2'b00, 32'h0, 32'h0);
    do_fetch(32'h0000_0010, 32'hFF1F_F06F, 0);

    // JAL backwards, JALR with bit 0 set, AUIPC as PC+4.
    retire(2'b01, 32'hFFFF_FFF0, 32'h0);
    do_fetch(32'h0000_0000, 32'h0400_0067, 2);
    retire(2'b10, 32'h0, 32'h0000_0041);
    do_fetch(32'h0000_0040, 32'h0000_1297, 0);
    retire(2'b11, 32'h0000_1000, 32'h0);
    do_fetch(32'h0000_0044, 32'h1234_5678, 0);

    // Backpressure with a stray ack and churning next-PC inputs.
    for (int i = 0; i < 10; i++) begin
      bus.imem_ack    = (i == 4);
      bus.imem_rdata  = 32'hDEAD_BEEF;
      bus.next_pc_sel = 2'(i);
      bus.jalr_target = 32'h0000_0022;
      @(negedge clk);
      chk("bp_enc",   bus.inst_encoding, 32'h1234_5678);
      chk("bp_pc",    bus.inst_pc,       32'h0000_0044);
      chk("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("bp_req",   {31'd0, bus.imem_req},   32'd0);
    end
    bus.imem_ack = 1'b0;

    // Wrap-around of PC+4.
    retire(2'b10, 32'h0, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0013, 0);
    retire(2'b00, 32'h0, 32'h0);
    do_fetch(32'h0000_0000, 32'h0220_0067, 1);

    // Misaligned JALR target halts fetch.
    retire(2'b10, 32'h0, 32'h0000_0022);
    chk("misaligned", {31'd0, bus.misaligned}, 32'd1);
    chk("halt_addr",  bus.imem_addr, 32'h0000_0022);
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack   = i[0];
      bus.inst_ready = i[1];
      @(negedge clk);
      chk("halt_req",   {31'd0, bus.imem_req},   32'd0);
      chk("halt_valid", {31'd0, bus.inst_valid}, 32'd0);
    end
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b0;
    chk("misal_sticky", {31'd0, bus.misaligned}, 32'd1);

    // Reset clears the halt, then starve the fetch into timeout.
    rst = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        chk("pre_timeout", {31'd0, bus.fetch_timeout}, 32'd0);
      end
    end
    chk("timeout",       {31'd0, bus.fetch_timeout}, 32'd1);
    chk("timeout_req",   {31'd0, bus.imem_req},      32'd1);
    chk("timeout_valid", {31'd0, bus.inst_valid},    32'd0);

    // Reset with ack pending; the late ack must be ignored.
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    rst            = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("late_ack_enc",   bus.inst_encoding, 32'h0000_0013);
    chk("late_ack_req",   {31'd0, bus.imem_req}, 32'd1);
    chk("late_timeout",   {31'd0, bus.fetch_timeout}, 32'd0);
    do_fetch(32'h0000_0000, 32'h00A0_0513, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the decode stage in the RV32 core.
- Owns the program counter, issues instruction-memory reads over a req/ack handshake, and presents one fetched instruction plus its PC to decode.
- Consumes decode's 2-bit next-PC select, together with the immediate and JALR target from the datapath, to form the next PC once decode retires the held instruction.
- Multi-cycle and non-pipelined: exactly one instruction is in flight at a time.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- STALL_LIMIT, 16, number of consecutive FETCH cycles without imem_ack before the fetch_timeout flag is set.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  word-aligned fetch address; equals pc.
- imem_ack  input  1  memory has valid data this cycle.
- imem_rdata  input  32  instruction word; sampled only when imem_req && imem_ack.
- inst_valid  output  1  inst_encoding and inst_pc hold a valid instruction for decode.
- inst_ready  input  1  decode/execute finished with the held instruction this cycle.
- inst_encoding  output  32  registered instruction word to decode.
- inst_pc  output  32  PC of the held instruction.
- next_pc_sel  input  2  from decode: 00 = PC+4, 01 = PC+imm (JAL / taken branch), 10 = JALR, 11 = AUIPC (treated as PC+4).
- pc_imm  input  32  sign-extended J/B immediate.
- jalr_target  input  32  rs1+imm from the ALU.
- misaligned  output  1  sticky: a non-word-aligned target was computed; fetch is halted.
- fetch_timeout  output  1  sticky: STALL_LIMIT reached within a single fetch.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0, inst_valid=0, inst_encoding=32'h0000_0013 (NOP), inst_pc=RESET_PC, misaligned=0, fetch_timeout=0, stall counter=0.
- States are FETCH, HOLD and HALT.
- FETCH:
  - imem_req=1 combinationally in this state, but not in the first cycle after rst deasserts (a one-cycle req-suppress flop is cleared by reset).
  - imem_addr=pc.
  - On imem_ack: inst_encoding<=imem_rdata, inst_pc<=pc, inst_valid<=1, stall counter<=0, go to HOLD.
  - Otherwise the stall counter increments. When it reaches STALL_LIMIT, fetch_timeout<=1 and the block stays in FETCH, still requesting.
- Minimum latency: if ack arrives in the same cycle as req, inst_valid rises on the next edge.
- HOLD:
  - imem_req=0 and inst_valid=1; inst_encoding and inst_pc are held stable.
  - On inst_ready: compute next_pc, clear inst_valid, and either go to FETCH with pc<=next_pc, or go to HALT if next_pc[1:0]!=0.
  - Without inst_ready, stay in HOLD indefinitely.
- next_pc calculation:
  - 00 or 11: inst_pc+4.
  - 01: inst_pc+pc_imm.
  - 10: {jalr_target[31:1],1'b0}.
  - All adds are 32-bit and wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Misaligned target: the check is applied after JALR bit-0 clearing, so a JALR target ending in 2'b01 is legal and one ending in 2'b10 is not. On a misaligned target: misaligned<=1 and pc<=the misaligned target (kept for debug); the block does not request.
- HALT: terminal. imem_req=0, inst_valid=0; only rst exits.
- Ignored inputs:
  - imem_ack while imem_req=0 (any state) is ignored and imem_rdata is not sampled.
  - inst_ready while inst_valid=0 is ignored.
- next_pc_sel, pc_imm and jalr_target are sampled only in the HOLD&&inst_ready cycle. Decode drives next_pc_sel combinationally from inst_encoding, so it is valid in that cycle.
- Reset mid-operation: asserting rst in any state (including FETCH with ack pending) returns every output to its reset value immediately. A late ack after reset is ignored because of the suppress cycle.
- Sticky flags clear only on rst.

Test Plan:
- Reset sequencing: RESET_PC=0; release rst; ack in the same cycle as req with rdata 32'h0050_0093 -> imem_req=0 in the first post-reset cycle, req with addr 0 in the second cycle, then inst_valid=1, inst_encoding=32'h0050_0093, inst_pc=0.
- Sequential fetch with memory wait states: ack delayed 3 cycles each fetch, inst_ready immediate, next_pc_sel=00 -> addrs 0, 4, 8; inst_valid low while waiting; fetch_timeout stays 0.
- JAL then JALR: in HOLD at pc 32'h10, sel=01 with pc_imm=32'hFFFF_FFF0 -> next addr 0. Then sel=10 with jalr_target=32'h0000_0041 -> next addr 32'h40.
- Misaligned target and backpressure: jalr_target=32'h0000_0022 -> misaligned=1, state HALT, imem_req stays 0 for 20 cycles. Separately, holding inst_ready=0 for 10 cycles keeps inst_encoding and inst_pc unchanged.
- Timeout and mid-fetch reset: STALL_LIMIT=16, ack never asserted -> fetch_timeout=1 after 16 FETCH cycles, req still high. Then assert rst with ack pending -> all outputs at reset values, and the ack in the next cycle is ignored.
- Wrap-around and stray handshakes: pc=32'hFFFF_FFFC with sel=00 -> next addr 0. A stray ack during HOLD does not change inst_encoding.
